// File: rtl/spike_packer.sv
// Packs 2-bit spike pairs from the neuron stage into 4-bit words and buffers them
// in a FIFO. Also keeps a saturating count of accepted spike bits and a sticky drop flag.
module spike_packer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [1:0]               spike_in,
  input  logic                     active_group_in,
  input  logic                     flush,
  input  logic                     clr,
  input  logic                     rd_en,
  output logic [3:0]               spike_out,
  output logic                     active_group_out,
  output logic                     out_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         spike_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [4:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [1:0]       pend_spk_q, pend_spk_d;
  logic             pend_grp_q, pend_grp_d;
  logic [3:0]       spike_out_q;
  logic             grp_out_q, out_valid_q, overflow_q;
  logic [CNT_W-1:0] spike_count_q, spike_count_d;

  logic             wr_req, wr_grp, do_wr, do_rd;
  logic [3:0]       wr_word;
  logic [1:0]       pop;
  logic [CNT_W:0]   sum;

  // Pairing: a lone half waits in pend until its partner or a flush arrives.
  always_comb begin
    wr_req     = 1'b0;
    wr_word    = 4'b0000;
    wr_grp     = 1'b0;
    pend_d     = pend_q;
    pend_spk_d = pend_spk_q;
    pend_grp_d = pend_grp_q;
    if (valid_in) begin
      if (pend_q) begin
        wr_req  = 1'b1;
        wr_word = {spike_in, pend_spk_q};
        wr_grp  = active_group_in | pend_grp_q;
        pend_d  = 1'b0;
      end else if (flush) begin
        wr_req  = 1'b1;
        wr_word = {2'b00, spike_in};
        wr_grp  = active_group_in;
      end else begin
        pend_d     = 1'b1;
        pend_spk_d = spike_in;
        pend_grp_d = active_group_in;
      end
    end else if (flush && pend_q) begin
      wr_req  = 1'b1;
      wr_word = {2'b00, pend_spk_q};
      wr_grp  = pend_grp_q;
      pend_d  = 1'b0;
    end
  end

  // A full FIFO still accepts a write when the same cycle frees the head slot.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_req & (~full | do_rd);

  always_comb begin
    cnt_d = cnt_q;
    if (do_wr && !do_rd)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_wr && do_rd) cnt_d = cnt_q - (AW+1)'(1);
  end

  assign pop = {1'b0, spike_in[0]} + {1'b0, spike_in[1]};
  assign sum = {1'b0, spike_count_q} + {{(CNT_W-1){1'b0}}, pop};

  always_comb begin
    spike_count_d = spike_count_q;
    if (valid_in) spike_count_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst && !clr && do_wr) mem_q[wr_ptr_q] <= {wr_grp, wr_word};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      pend_spk_q    <= 2'b00;
      pend_grp_q    <= 1'b0;
      spike_out_q   <= 4'b0000;
      grp_out_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      overflow_q    <= 1'b0;
      spike_count_q <= '0;
    end else if (clr) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      pend_spk_q    <= 2'b00;
      pend_grp_q    <= 1'b0;
      grp_out_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      overflow_q    <= 1'b0;
      spike_count_q <= '0;
    end else begin
      pend_q        <= pend_d;
      pend_spk_q    <= pend_spk_d;
      pend_grp_q    <= pend_grp_d;
      cnt_q         <= cnt_d;
      spike_count_q <= spike_count_d;
      out_valid_q   <= do_rd;
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        spike_out_q <= mem_q[rd_ptr_q][3:0];
        grp_out_q   <= mem_q[rd_ptr_q][4];
      end
      if (wr_req && !do_wr) overflow_q <= 1'b1;
    end
  end

  assign spike_out        = spike_out_q;
  assign active_group_out = grp_out_q;
  assign out_valid        = out_valid_q;
  assign count            = cnt_q;
  assign empty            = (cnt_q == '0);
  assign full             = (cnt_q == DEPTH_C);
  assign spike_count      = spike_count_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_spike_packer.sv
// Directed bench for spike_packer: packing, flush, FIFO boundaries, clear and async reset.
module tb_spike_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [1:0]  spike_in = 2'b00;
  logic        active_group_in = 1'b0;
  logic        flush = 1'b0;
  logic        clr = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  spike_out;
  logic        active_group_out, out_valid, empty, full, overflow;
  logic [4:0]  count;
  logic [15:0] spike_count;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  spike_packer #(.DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .spike_in(spike_in),
    .active_group_in(active_group_in), .flush(flush), .clr(clr), .rd_en(rd_en),
    .spike_out(spike_out), .active_group_out(active_group_out), .out_valid(out_valid),
    .empty(empty), .full(full), .count(count), .spike_count(spike_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [1:0] s, input logic g,
                     input logic f, input logic r, input logic c);
    valid_in = v; spike_in = s; active_group_in = g; flush = f; rd_en = r; clr = c;
    @(posedge clk); #1;
    valid_in = 1'b0; spike_in = 2'b00; active_group_in = 1'b0;
    flush = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic push_word(input logic [3:0] w, input logic g, input logic model);
    cyc(1'b1, w[1:0], g, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, w[3:2], 1'b0, 1'b0, 1'b0, 1'b0);
    if (model) exp_q.push_back({g, w});
  endtask

  task automatic chk_out(input string tag);
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s observed=read expected=no_data", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, 32'(spike_out), 32'(e[3:0]));
      chk({tag, "_grp"}, 32'(active_group_out), 32'(e[4]));
    end
  endtask

  task automatic rd_check(input string tag);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_out(tag);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_spike_out", 32'(spike_out), 32'd0);
    chk("rst_grp", 32'(active_group_out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_sc", 32'(spike_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    // Basic packing: 01 (g1) then 10 (g0) -> 1001, group 1
    cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pack_half_nowrite", 32'(count), 32'd0);
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pack_count", 32'(count), 32'd1);
    chk("pack_empty", 32'(empty), 32'd0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pack_valid", 32'(out_valid), 32'd1);
    chk("pack_data", 32'(spike_out), 32'h9);
    chk("pack_grp", 32'(active_group_out), 32'd1);
    chk("pack_sc", 32'(spike_count), 32'd2);
    chk("pack_empty_after", 32'(empty), 32'd1);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pulse_valid", 32'(out_valid), 32'd0);
    chk("hold_data", 32'(spike_out), 32'h9);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rd_empty_valid", 32'(out_valid), 32'd0);
    chk("rd_empty_count", 32'(count), 32'd0);

    // Odd flush: 11 then flush -> 0011; second flush writes nothing
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_count", 32'(count), 32'd1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush2_count", 32'(count), 32'd1);
    exp_q.push_back({1'b0, 4'b0011});
    rd_check("flush_rd");
    chk("flush_sc", 32'(spike_count), 32'd4);

    // Flush together with valid_in, both pend states
    cyc(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("vflush_np_count", 32'(count), 32'd1);
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("vflush_p_count", 32'(count), 32'd2);
    exp_q.push_back({1'b1, 4'b0010});
    exp_q.push_back({1'b0, 4'b1101});
    rd_check("vflush_np_rd");
    rd_check("vflush_p_rd");
    chk("vflush_sc", 32'(spike_count), 32'd8);

    // clr wins over valid_in, flush and rd_en; spike_out keeps its value
    push_word(4'h5, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_sc", 32'(spike_count), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_hold_data", 32'(spike_out), 32'hD);
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_pend_cleared", 32'(count), 32'd0);
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 4'b1001});
    rd_check("clr_after_rd");

    // Overflow: 17 words into a 16-deep FIFO, the 17th is dropped
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) push_word(4'(i), i[0], 1'b1);
    chk("pre_ovf_full", 32'(full), 32'd1);
    chk("pre_ovf_flag", 32'(overflow), 32'd0);
    push_word(4'hA, 1'b1, 1'b0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_sc", 32'(spike_count), 32'd34);
    for (int i = 0; i < 16; i++) rd_check("ovf_drain");
    chk("ovf_drain_empty", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full with same-cycle read and write
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) push_word(4'(15 - i), i[1], 1'b1);
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_out("full_rw");
    exp_q.push_back({1'b1, 4'b0110});
    chk("full_rw_count", 32'(count), 32'd16);
    chk("full_rw_full", 32'(full), 32'd1);
    chk("full_rw_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) rd_check("full_rw_drain");
    chk("full_rw_empty", 32'(empty), 32'd1);

    // Wrap: 40 words with interleaved reads
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] w;
      logic       r, hit;
      w = 4'((i * 5 + 1) % 16);
      r = (i % 3) != 2;
      hit = r && (exp_q.size() != 0);
      cyc(1'b1, w[1:0], i[1], 1'b0, 1'b0, 1'b0);
      cyc(1'b1, w[3:2], 1'b0, 1'b0, r, 1'b0);
      if (hit) chk_out("wrap_rd");
      else chk("wrap_novalid", 32'(out_valid), 32'd0);
      exp_q.push_back({i[1], w});
    end
    chk("wrap_count", 32'(count), 32'(exp_q.size()));
    while (exp_q.size() != 0) rd_check("wrap_drain");
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_ovf", 32'(overflow), 32'd0);

    // Reset mid-stream discards stored words and the pending half at once
    push_word(4'h3, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_sc", 32'(spike_count), 32'd0);
    chk("arst_spike_out", 32'(spike_out), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst_first_half", 32'(count), 32'd0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst_word_count", 32'(count), 32'd1);
    exp_q.push_back({1'b0, 4'b0110});
    rd_check("arst_rd");
    chk("arst_sc_after", 32'(spike_count), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_packer.md
SPIKE_PACKER -- requirements
Module: spike_packer

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the FIFO depth in 4-bit words; legal values are powers of two, 2 or greater.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the spike counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port valid_in, input, 1: neuron-stage result strobe.
REQ-006 Port spike_in, input, 2: spike pair from the neuron stage.
REQ-007 Port active_group_in, input, 1: group-activity flag accompanying spike_in.
REQ-008 Port flush, input, 1: emit any pending half-word (end of layer pass).
REQ-009 Port clr, input, 1: synchronous clear of the FIFO, pending half-word, counter and overflow flag.
REQ-010 Port rd_en, input, 1: consumer read request.
REQ-011 Port spike_out, output, 4: packed spike word, suitable for the next pass's 4-bit spike input.
REQ-012 Port active_group_out, output, 1: group flag of the word on spike_out.
REQ-013 Port out_valid, output, 1: spike_out/active_group_out are valid this cycle.
REQ-014 Ports empty and full, output, 1 each: FIFO status.
REQ-015 Port count, output, clog2(DEPTH)+1: number of words held.
REQ-016 Port spike_count, output, CNT_W: total '1' spike bits accepted since reset or clr.
REQ-017 Port overflow, output, 1: sticky flag, a word was dropped.

Function
REQ-018 Packing: the first accepted valid_in SHALL store spike_in and active_group_in as the pending half and set pend.
REQ-019 Packing: the next valid_in SHALL form word {spike_in, pending}, so the first pair lands in bits [1:0]; the word's group flag is the OR of both halves; the word is written and pend is cleared.
REQ-020 Flush with pend=1 and no valid_in: write {2'b00, pending}, clear pend.
REQ-021 Flush with pend=0 and no valid_in: no write.
REQ-022 Flush with valid_in, pend=1: write {spike_in, pending}.
REQ-023 Flush with valid_in, pend=0: write {2'b00, spike_in}; pend stays 0.
REQ-024 Write-into-FIFO latency: one cycle after the completing valid_in or flush; count increments on that edge.
REQ-025 Read: when rd_en=1 and empty=0, the head word SHALL appear on spike_out with out_valid=1 on the next cycle.
REQ-026 Read: out_valid SHALL be a single-cycle pulse per read.
REQ-027 Read: spike_out holds its last value when no read occurs.
REQ-028 rd_en while empty SHALL be ignored: no pointer change, out_valid=0.
REQ-029 A write while full and no same-cycle read SHALL be dropped, set overflow, and leave the FIFO contents unchanged.
REQ-030 A write while full with a same-cycle read SHALL succeed; count is unchanged.
REQ-031 A simultaneous read and write when not full and not empty SHALL leave count unchanged.
REQ-032 Pointers SHALL wrap modulo DEPTH.
REQ-033 full = (count==DEPTH); empty = (count==0).
REQ-034 spike_count SHALL add popcount(spike_in) on every valid_in, including dropped words, and saturate at all-ones.
REQ-035 clr SHALL take priority over valid_in, flush and rd_en in the same cycle, producing the reset state except that spike_out keeps its value.

Reset
REQ-036 While rst=0: spike_out=0, active_group_out=0, out_valid=0, empty=1, full=0, count=0, spike_count=0, overflow=0, pend=0, pointers=0.
REQ-037 Assertion of rst mid-operation SHALL discard the pending half and all stored words immediately, without waiting for a clock edge.
REQ-038 After deassertion of rst, the first valid_in SHALL be treated as a first half.

Verification
REQ-039 Packing: valid_in with spike_in=01, then 10 (groups 1, 0), then rd_en -> spike_out=1001, active_group_out=1, out_valid=1 one cycle after rd_en, spike_count=2.
REQ-040 Odd flush: valid_in with spike_in=11, then flush -> one word 0011, count=1; flush again -> count stays 1.
REQ-041 Overflow: DEPTH=16, write 17 words, no reads -> full=1, count=16, overflow=1, FIFO contents equal the first 16 words.
REQ-042 Full with simultaneous read and write: write proceeds, count stays 16, overflow stays 0.
REQ-043 Wrap: 40 words streamed with interleaved reads -> output order is exact, no loss, and empty=1 at the end.
REQ-044 Reset mid-stream: rst=0 between two halves, then after release, pairs 10 and 01 -> word 0110, count=1.
